// File: rtl/gravsim_pkg.sv
// ----------------------------------------------------------------------------
// gravsim_pkg : shared field map, register offsets and address helper
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gravsim_pkg;

  typedef enum logic [3:0] {
    F_MASS = 4'd0,
    F_RAD  = 4'd1,
    F_PX   = 4'd2,
    F_PY   = 4'd3,
    F_PZ   = 4'd4,
    F_VX   = 4'd5,
    F_VY   = 4'd6,
    F_VZ   = 4'd7,
    F_AX   = 4'd8,
    F_AY   = 4'd9,
    F_AZ   = 4'd10
  } field_e;

  typedef enum logic [0:0] {
    RUN_IDLE = 1'b0,
    RUN_BUSY = 1'b1
  } run_state_e;

  localparam int unsigned N_FIELDS   = 11;
  localparam int unsigned MISC_WORDS = 4;

  localparam logic [7:0] ADDR_G      = 8'd0;
  localparam logic [7:0] ADDR_COUNT  = 8'd1;
  localparam logic [7:0] ADDR_CTRL   = 8'd2;
  localparam logic [7:0] ADDR_STATUS = 8'd3;

  localparam int CTRL_PAUSED_BIT    = 0;
  localparam int CTRL_PAUSE_REQ_BIT = 1;
  localparam int CTRL_STEP_BIT      = 2;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;
  localparam int STATUS_OVR_LSB  = 16;

  // Word address of one field of one body; fields are stored as contiguous
  // N_BODIES-long arrays after the misc registers.
  function automatic int unsigned body_addr(input field_e f, input int unsigned body,
                                            input int unsigned n_bodies);
    return MISC_WORDS + 32'(f) * n_bodies + body;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sim_run_ctrl.sv
// ----------------------------------------------------------------------------
// sim_run_ctrl : keyboard pause/step, frame-sync edge detect, run FSM, overrun
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sim_run_ctrl
  import gravsim_pkg::*;
#(
  parameter logic [7:0] KEY_PAUSE = 8'd44,
  parameter logic [7:0] KEY_STEP  = 8'd40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vga_vs,
  input  logic [7:0]  keycode,
  input  logic        host_pause_toggle,
  input  logic        host_step,
  input  logic        eng_done,
  output logic        eng_start,
  output logic        busy,
  output logic        done,
  output logic        paused,
  output logic [15:0] overrun,
  output logic        shadow_load
);

  run_state_e  state_q, state_d;
  logic        vs_q;
  logic [7:0]  key_q;
  logic        paused_q, paused_d;
  logic        step_q, step_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic [15:0] ovr_q, ovr_d;

  logic vs_rise, pause_edge, step_edge;

  assign vs_rise    = vga_vs & ~vs_q;
  assign pause_edge = (keycode == KEY_PAUSE) && (key_q != KEY_PAUSE);
  assign step_edge  = (keycode == KEY_STEP) && (key_q != KEY_STEP);

  always_comb begin
    state_d     = state_q;
    start_d     = 1'b0;
    shadow_load = 1'b0;
    ovr_d       = ovr_q;
    case (state_q)
      RUN_IDLE: begin
        if (vs_rise && (!paused_q || step_q)) begin
          start_d = 1'b1;
          state_d = RUN_BUSY;
        end
      end
      RUN_BUSY: begin
        // Completion wins over a coincident frame edge; the next edge starts.
        if (eng_done) begin
          state_d     = RUN_IDLE;
          shadow_load = 1'b1;
        end else if (vs_rise && (ovr_q != 16'hFFFF)) begin
          ovr_d = ovr_q + 16'd1;
        end
      end
      default: state_d = RUN_IDLE;
    endcase
    paused_d = paused_q ^ (pause_edge | host_pause_toggle);
    step_d   = (step_q & ~start_d) | step_edge | host_step;
    done_d   = (done_q & ~start_d) | eng_done;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RUN_IDLE;
      vs_q     <= 1'b0;
      key_q    <= 8'd0;
      paused_q <= 1'b0;
      step_q   <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      ovr_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      vs_q     <= vga_vs;
      key_q    <= keycode;
      paused_q <= paused_d;
      step_q   <= step_d;
      done_q   <= done_d;
      start_q  <= start_d;
      ovr_q    <= ovr_d;
    end
  end

  assign eng_start = start_q;
  assign busy      = (state_q == RUN_BUSY);
  assign done      = done_q;
  assign paused    = paused_q;
  assign overrun   = ovr_q;

endmodule

`default_nettype wire

// File: rtl/body_regfile_avl.sv
// ----------------------------------------------------------------------------
// body_regfile_avl : Avalon-MM body register file with engine ports and shadow
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module body_regfile_avl
  import gravsim_pkg::*;
#(
  parameter int unsigned N_BODIES  = 10,
  parameter int unsigned N_PORTS   = 6,
  parameter int unsigned N_DISP    = 4,
  parameter logic [7:0]  KEY_PAUSE = 8'd44,
  parameter logic [7:0]  KEY_STEP  = 8'd40
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       AVL_READ,
  input  logic                       AVL_WRITE,
  input  logic                       AVL_CS,
  input  logic [3:0]                 AVL_BYTE_EN,
  input  logic [7:0]                 AVL_ADDR,
  input  logic [31:0]                AVL_WRITEDATA,
  output logic [31:0]                AVL_READDATA,
  input  logic                       VGA_VS,
  input  logic [7:0]                 keycode,
  input  logic [N_PORTS-1:0][7:0]    ENG_ADDR,
  input  logic [N_PORTS-1:0][31:0]   ENG_WDATA,
  input  logic [N_PORTS-1:0]         ENG_WE,
  input  logic [N_PORTS-1:0]         ENG_RE,
  output logic [N_PORTS-1:0][31:0]   ENG_RDATA,
  output logic [N_PORTS-1:0]         ENG_RVALID,
  input  logic                       ENG_CLEAR_ACC,
  input  logic                       ENG_DONE,
  output logic                       ENG_START,
  output logic [N_DISP-1:0][31:0]    DISP_RAD,
  output logic [N_DISP-1:0][31:0]    DISP_X,
  output logic [N_DISP-1:0][31:0]    DISP_Y,
  output logic [N_DISP-1:0][31:0]    DISP_Z
);

  localparam int unsigned DEPTH = MISC_WORDS + N_FIELDS * N_BODIES;

  logic [31:0] words_q [DEPTH];
  logic [31:0] words_d [DEPTH];

  logic [31:0]              avl_rdata_q, avl_rdata_d;
  logic [N_PORTS-1:0][31:0] eng_rdata_q, eng_rdata_d;
  logic [N_PORTS-1:0]       eng_rvalid_q;
  logic [N_DISP-1:0][31:0]  disp_rad_q, disp_rad_d;
  logic [N_DISP-1:0][31:0]  disp_x_q, disp_x_d;
  logic [N_DISP-1:0][31:0]  disp_y_q, disp_y_d;
  logic [N_DISP-1:0][31:0]  disp_z_q, disp_z_d;

  logic        avl_wr, avl_rd;
  logic        host_pause_toggle, host_step;
  logic        run_busy, run_done, run_paused, shadow_load;
  logic [15:0] run_overrun;
  logic [31:0] status_word;

  assign avl_wr = AVL_CS & AVL_WRITE;
  assign avl_rd = AVL_CS & AVL_READ;

  assign host_pause_toggle = avl_wr && (AVL_ADDR == ADDR_CTRL) && AVL_BYTE_EN[0]
                             && AVL_WRITEDATA[CTRL_PAUSE_REQ_BIT];
  assign host_step         = avl_wr && (AVL_ADDR == ADDR_CTRL) && AVL_BYTE_EN[0]
                             && AVL_WRITEDATA[CTRL_STEP_BIT];

  always_comb begin
    status_word                  = '0;
    status_word[STATUS_DONE_BIT] = run_done;
    status_word[STATUS_BUSY_BIT] = run_busy;
    status_word[31:STATUS_OVR_LSB] = run_overrun;
  end

  sim_run_ctrl #(
    .KEY_PAUSE (KEY_PAUSE),
    .KEY_STEP  (KEY_STEP)
  ) u_run_ctrl (
    .clk               (CLK),
    .rst_n             (RESET_N),
    .vga_vs            (VGA_VS),
    .keycode           (keycode),
    .host_pause_toggle (host_pause_toggle),
    .host_step         (host_step),
    .eng_done          (ENG_DONE),
    .eng_start         (ENG_START),
    .busy              (run_busy),
    .done              (run_done),
    .paused            (run_paused),
    .overrun           (run_overrun),
    .shadow_load       (shadow_load)
  );

  // CTRL and STATUS are live views; all reads see the word before this cycle's writes.
  function automatic logic [31:0] read_word(input logic [7:0] a);
    logic [31:0] v;
    v = '0;
    if (a == ADDR_CTRL) begin
      v[CTRL_PAUSED_BIT] = run_paused;
    end else if (a == ADDR_STATUS) begin
      v = status_word;
    end else if (32'(a) < DEPTH) begin
      v = words_q[a];
    end
    return v;
  endfunction

  // Later assignments override earlier ones: clear < engine port (rising index) < Avalon.
  always_comb begin
    words_d = words_q;
    if (ENG_CLEAR_ACC) begin
      for (int unsigned w = body_addr(F_AX, 0, N_BODIES); w < DEPTH; w++) begin
        words_d[w] = '0;
      end
    end
    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (ENG_WE[p] && (32'(ENG_ADDR[p]) >= MISC_WORDS) && (32'(ENG_ADDR[p]) < DEPTH)) begin
        words_d[ENG_ADDR[p]] = ENG_WDATA[p];
      end
    end
    if (avl_wr && (32'(AVL_ADDR) < DEPTH) && (AVL_ADDR != ADDR_CTRL)
        && (AVL_ADDR != ADDR_STATUS)) begin
      for (int b = 0; b < 4; b++) begin
        if (AVL_BYTE_EN[b]) begin
          words_d[AVL_ADDR][8*b +: 8] = AVL_WRITEDATA[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    avl_rdata_d = avl_rd ? read_word(AVL_ADDR) : avl_rdata_q;
    eng_rdata_d = eng_rdata_q;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (ENG_RE[p]) begin
        eng_rdata_d[p] = read_word(ENG_ADDR[p]);
      end
    end
  end

  always_comb begin
    disp_rad_d = disp_rad_q;
    disp_x_d   = disp_x_q;
    disp_y_d   = disp_y_q;
    disp_z_d   = disp_z_q;
    if (shadow_load) begin
      for (int unsigned i = 0; i < N_DISP; i++) begin
        disp_rad_d[i] = words_q[body_addr(F_RAD, i, N_BODIES)];
        disp_x_d[i]   = words_q[body_addr(F_PX, i, N_BODIES)];
        disp_y_d[i]   = words_q[body_addr(F_PY, i, N_BODIES)];
        disp_z_d[i]   = words_q[body_addr(F_PZ, i, N_BODIES)];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int unsigned w = 0; w < DEPTH; w++) begin
        words_q[w] <= '0;
      end
      avl_rdata_q  <= '0;
      eng_rdata_q  <= '0;
      eng_rvalid_q <= '0;
      disp_rad_q   <= '0;
      disp_x_q     <= '0;
      disp_y_q     <= '0;
      disp_z_q     <= '0;
    end else begin
      words_q      <= words_d;
      avl_rdata_q  <= avl_rdata_d;
      eng_rdata_q  <= eng_rdata_d;
      eng_rvalid_q <= ENG_RE;
      disp_rad_q   <= disp_rad_d;
      disp_x_q     <= disp_x_d;
      disp_y_q     <= disp_y_d;
      disp_z_q     <= disp_z_d;
    end
  end

  assign AVL_READDATA = avl_rdata_q;
  assign ENG_RDATA    = eng_rdata_q;
  assign ENG_RVALID   = eng_rvalid_q;
  assign DISP_RAD     = disp_rad_q;
  assign DISP_X       = disp_x_q;
  assign DISP_Y       = disp_y_q;
  assign DISP_Z       = disp_z_q;

endmodule

`default_nettype wire
